// File: rtl/mem_req_arbiter.sv
// Two-to-one sram-like request arbiter with in-order response routing; `ARB_ROUND_ROBIN_EN` swaps fixed priority for round-robin.
// Latency: zero-cycle forwarding of the selected request and of each data_ok to the requester that issued it.
// Backpressure: the winner is held until mem_addr_ok; mem_req is withheld while OUTS_DEPTH transactions are outstanding.
module mem_req_arbiter #(
    parameter int OUTS_DEPTH = 4,
    parameter int CNT_W      = $clog2(OUTS_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_t;

    localparam int PTR_W = $clog2(OUTS_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTS_DEPTH);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q;
    logic [PTR_W-1:0]       wptr_q, rptr_q;
    logic [OUTS_DEPTH-1:0]  src_q;      // 1 = data requester, 0 = inst requester
    logic                   arb_err_q;
    logic                   sel_vld, sel_data, idle_pick_data;
    logic                   not_full, push, pop, head_data;
    req_t                   inst_fields, data_fields, mem_fields;

    assign not_full = count_q < DEPTH_C;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // On a collision the requester that did not win last time goes first.
    assign idle_pick_data = data_req & (~inst_req | ~last_grant_q);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant_q <= 1'b0;
        else if (push)
            last_grant_q <= sel_data;
    end
`else
    assign idle_pick_data = data_req;
`endif

    always_comb begin
        state_d  = state_q;
        sel_vld  = 1'b0;
        sel_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (not_full && (inst_req || data_req)) begin
                    sel_vld  = 1'b1;
                    sel_data = idle_pick_data;
                    if (!mem_addr_ok)
                        state_d = idle_pick_data ? HOLD_DATA : HOLD_INST;
                end
            end
            HOLD_INST: begin
                sel_vld = inst_req;
                if (!inst_req || mem_addr_ok)
                    state_d = IDLE;
            end
            HOLD_DATA: begin
                sel_data = 1'b1;
                sel_vld  = data_req;
                if (!data_req || mem_addr_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                           addr: inst_addr, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                           addr: data_addr, wdata: data_wdata};
    assign mem_fields  = sel_data ? data_fields : inst_fields;

    assign mem_req   = sel_vld & ~reset;
    assign mem_wr    = mem_fields.wr;
    assign mem_size  = mem_fields.size;
    assign mem_wstrb = mem_fields.wstrb;
    assign mem_addr  = mem_fields.addr;
    assign mem_wdata = mem_fields.wdata;

    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & ~sel_data;
    assign data_addr_ok = push & sel_data;

    // Stray responses (nothing outstanding) are dropped, never routed.
    assign pop          = mem_data_ok & (count_q != '0) & ~reset;
    assign head_data    = src_q[rptr_q];
    assign inst_data_ok = pop & ~head_data;
    assign data_data_ok = pop & head_data;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign arb_err      = arb_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            src_q     <= '0;
            arb_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                src_q[wptr_q] <= sel_data;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop)
                rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (mem_data_ok && count_q == '0)
                arb_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: per-cycle comparison against a queue-based model plus literal spot checks.
module tb_mem_req_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_arbiter #(.OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: queue of issuing sources in acceptance order, plus which requester (if any) is being held.
    bit q[$];
    int m_held = -1;
    bit m_err  = 1'b0;
    bit m_lg   = 1'b0;
    int m_s;
    bit m_req, m_pop, m_head, m_stray;

    always @(negedge clk) begin
        m_s = 0;
        m_req = 1'b0;
        if (m_held >= 0) begin
            m_s   = m_held;
            m_req = (m_held == 1) ? data_req : inst_req;
        end else if (q.size() < DEPTH && (inst_req || data_req)) begin
            m_req = 1'b1;
            if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_s = m_lg ? 0 : 1;
`else
                m_s = 1;
`endif
            end else begin
                m_s = data_req ? 1 : 0;
            end
        end
        if (reset) m_req = 1'b0;
        m_stray = !reset && mem_data_ok && q.size() == 0;
        m_pop   = !reset && mem_data_ok && q.size() > 0;
        m_head  = m_pop ? q[0] : 1'b0;

        chk("mem_req", mem_req, m_req);
        chk("inst_addr_ok", inst_addr_ok, m_req && mem_addr_ok && m_s == 0);
        chk("data_addr_ok", data_addr_ok, m_req && mem_addr_ok && m_s == 1);
        chk("inst_data_ok", inst_data_ok, m_pop && !m_head);
        chk("data_data_ok", data_data_ok, m_pop && m_head);
        chk("arb_err", arb_err, m_err);
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        if (m_req) begin
            chk("mem_addr", mem_addr, m_s == 1 ? data_addr : inst_addr);
            chk("mem_wdata", mem_wdata, m_s == 1 ? data_wdata : inst_wdata);
            chk("mem_ctl", {mem_wr, mem_size, mem_wstrb},
                m_s == 1 ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
        end

        if (reset) begin
            q.delete();
            m_held = -1;
            m_err  = 1'b0;
            m_lg   = 1'b0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_req && mem_addr_ok) begin
                q.push_back(m_s == 1);
                m_lg = (m_s == 1);
            end
            m_held = (m_req && !mem_addr_ok) ? m_s : -1;
            if (m_stray) m_err = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'hCAFE0000;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        clr();
        inst_addr = 32'h0; data_addr = 32'h0; mem_rdata = 32'h0;
        reset = 1'b1;
        inst_req = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        tick();
        chk("rst_arb_err", arb_err, 0);
        reset = 1'b0; clr();

        // Single fetch, response two cycles later
        inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
        @(negedge clk);
        chk("t1_mem_addr", mem_addr, 32'h1C000000);
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        tick(); clr();
        tick();
        mem_data_ok = 1; mem_rdata = 32'h02800C00;
        @(negedge clk);
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h02800C00);
        chk("t1_data_data_ok", data_data_ok, 0);
        tick(); clr();

        // Collision: data first, then inst; responses in that order
        inst_req = 1; inst_addr = 32'h1C000004; data_req = 1; data_addr = 32'h00000100; mem_addr_ok = 1;
        @(negedge clk);
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok0", inst_addr_ok, 0);
        chk("t2_mem_addr", mem_addr, 32'h00000100);
        tick();
`ifndef ARB_ROUND_ROBIN_EN
        data_req = 0;
`endif
        @(negedge clk);
        chk("t2_inst_addr_ok", inst_addr_ok, 1);
        chk("t2_data_addr_ok0", data_addr_ok, 0);
        tick(); clr();
        mem_data_ok = 1; mem_rdata = 32'h11111111;
        @(negedge clk);
        chk("t2_resp1_data", data_data_ok, 1);
        tick();
        mem_rdata = 32'h22222222;
        @(negedge clk);
        chk("t2_resp2_inst", inst_data_ok, 1);
        tick(); clr();

        // Hold data for three refused cycles while inst waits
        data_req = 1; data_addr = 32'h00000200; inst_req = 1; inst_addr = 32'h1C000008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_addr", mem_addr, 32'h00000200);
            chk("t3_hold_no_ok", data_addr_ok, 0);
            tick();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        chk("t3_data_addr_ok", data_addr_ok, 1);
        chk("t3_inst_wait", inst_addr_ok, 0);
        tick();
        data_req = 0;
        @(negedge clk);
        chk("t3_inst_granted", inst_addr_ok, 1);
        tick(); clr();
        mem_data_ok = 1;
        tick(); tick(); clr();

        // Fill to depth, then pop and push in consecutive cycles
        inst_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < DEPTH; i++) begin
            inst_addr = 32'h1C001000 + 32'(i * 4);
            tick();
        end
        @(negedge clk);
        chk("t4_full_mem_req", mem_req, 0);
        chk("t4_full_no_ok", inst_addr_ok, 0);
        tick();
        mem_data_ok = 1;
        @(negedge clk);
        chk("t4_pop", inst_data_ok, 1);
        chk("t4_no_push", mem_req, 0);
        tick();
        mem_data_ok = 0;
        @(negedge clk);
        chk("t4_push_next", inst_addr_ok, 1);
        tick(); clr();
        mem_data_ok = 1;
        for (int i = 0; i < DEPTH; i++) tick();
        clr();

        // Drop data_req while held: abandoned, nothing recorded
        data_req = 1; data_addr = 32'h00000300;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h1C00000C;
        @(negedge clk);
        chk("t5_drop_mem_req", mem_req, 0);
        tick();
        mem_addr_ok = 1;
        @(negedge clk);
        chk("t5_idle_inst_ok", inst_addr_ok, 1);
        tick(); clr();
        mem_data_ok = 1;
        @(negedge clk);
        chk("t5_only_inst", inst_data_ok, 1);
        chk("t5_no_data", data_data_ok, 0);
        tick();

        // Stray response
        @(negedge clk);
        chk("t6_stray_inst", inst_data_ok, 0);
        chk("t6_stray_data", data_data_ok, 0);
        tick(); clr();
        @(negedge clk);
        chk("t6_err_set", arb_err, 1);
        tick(); tick();
        chk("t6_err_sticky", arb_err, 1);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("t6_err_clear", arb_err, 0);
        tick();

        // Reset mid-transaction: the later response is stray
        inst_req = 1; inst_addr = 32'h1C000010; mem_addr_ok = 1;
        tick(); clr();
        reset = 1;
        tick();
        reset = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("t7_not_routed", inst_data_ok, 0);
        tick(); clr();
        @(negedge clk);
        chk("t7_err", arb_err, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
